base_arr_dist: RTL and testbench
================================

Name: base_arr_dist

Overview:
Round-robin distributor with hold. It steers one valid/ready input stream to one of `ways` output lanes. It is the fan-out counterpart of the codebase's N-to-1 hold-capable arbiter.
- Each lane has a one-entry output register.
- Multi-beat transfers (input hold asserted) stay locked to one lane until the final beat.
- Sits between a single producer and replicated consumer engines.

Parameters:
ways, 1, number of output lanes (>=1)
width, 1, payload bits per beat

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
i_r  output  1  input ready
i_v  input  1  input valid
i_h  input  1  hold: more beats follow; keep the same lane
i_d  input  width  input payload
o_r  input  ways  per-lane ready, index 0 = lane 0
o_v  output  ways  per-lane valid
o_h  output  ways  per-lane hold, registered copy of i_h for the beat in the lane register
o_d  output  ways*width  lane w payload at bits [w*width : w*width+width-1]
o_s  output  ways  one-hot target lane for the current cycle; all-zero when no lane is eligible

Behaviour:
- Interface: one clock, `clk`; reset is synchronous and active-high, `reset`.
- Lane state, per lane w:
  - Fields: valid, hold, data.
  - Lane drains when o_v[w] & o_r[w].
  - Lane is free when ~o_v[w] (macro off). See Optional Feature for macro on.
- Distributor state:
  - Priority pointer p, range 0..ways-1; may be held as a thermometer mask.
  - Lock flag lk and lock lane lw.
- Target selection, combinational:
  - If lk: target = lw if lw is free, otherwise none.
  - If ~lk: target = first free lane scanning p, p+1, ..., wrapping mod ways.
  - o_s = one-hot target, or 0 if none.
- Ready and transfer:
  - i_r = (target exists). i_r does not depend on i_v.
  - Transfer = i_v & i_r. On transfer, the target lane loads valid=1, hold=i_h, data=i_d.
- State updates on transfer to lane g:
  - i_h=1: lk<=1, lw<=g, p unchanged.
  - i_h=0: lk<=0, p<=(g+1) mod ways.
  - No transfer: lk, lw and p unchanged.
- Lane update:
  - Drain without load: valid<=0.
  - Load in the same cycle as drain: the load wins and valid stays 1.
  - Data and hold registers change only on load.
- Latency: one cycle from input transfer to o_v.
- Ordering: beats within a locked burst stay in order on lw. No ordering guarantee across lanes.
- Locked stall: i_r stays 0 until lw frees, even if other lanes are free.
- Dropping i_v while locked keeps the lock; the burst may be resumed later.
- ways=1: always lane 0; p and lw are constant 0.
- Reset: o_v=0, o_h=0, lk=0, p=0; o_d is don't-care. In-flight lane contents are discarded, and a locked burst is abandoned.

Optional Feature:
Macro BASE_ARR_DIST_RDY_PASS_EN.
- Without it: a lane is free only when empty. No combinational path from o_r to i_r. Per-lane throughput is 1 beat per 2 cycles.
- With it: a lane is also free when o_v[w] & o_r[w]. Combinational o_r->i_r path; per-lane throughput is 1 beat per cycle.
- All other behaviour is identical.

Decomposition:
- No shared package needed: no typedefs.
- If reused, place a ceil-log2 helper function in base_pkg.
- Sub-module base_arr_dist_lane: one-entry register with load/drain, holding valid/hold/data and producing the free flag. Instantiated `ways` times.
- The free-lane scan uses the existing base_prienc_hp on a doubled (rotated) vector.
- State registers use base_vlat_en.

Test Plan:
1. ways=4, width=8, macro off, all o_r=1, i_v=1, i_h=0, data 0x10,0x11,... -> o_v one-hot rotates lane 0,1,2,3,0 starting cycle 1. o_d of lane k = 0x10+k; i_r never drops.
2. ways=4, o_r=0 on all lanes, stream 5 beats -> lanes 0-3 fill, i_r=0 from cycle 4. Raise o_r[2] -> lane 2 drains and the 5th beat loads lane 2 next cycle.
3. ways=4, p=1, burst i_h=1,1,0 with data 0xA0,0xA1,0xA2, lane 1 o_r=1 -> all three beats go to lane 1 with o_h=1,1,0; p=2 afterward.
4. Locked on lane 1, o_r[1]=0, lanes 0/2/3 empty -> i_r=0 until o_r[1]=1; no beat appears on another lane.
5. ways=1, macro off vs on, o_r=1, continuous i_v -> accept every other cycle (off) vs every cycle (on).
6. Assert reset mid-burst with lanes full -> next cycle o_v=0, lk=0, p=0; the first post-reset beat goes to lane 0.

Source files
------------

// File: rtl/base_arr_dist_pkg.sv
// Shared helpers for the round-robin distributor slice.
package base_arr_dist_pkg;

  // Bits needed to index n items; never less than one so that n=1 still
  // yields a legal vector width.
  function automatic int unsigned ptr_bits(input int unsigned n);
    int unsigned b;
    b = 1;
    while ((32'd1 << b) < n) b++;
    return b;
  endfunction

endpackage

// File: rtl/base_arr_dist_lane.sv
// One-entry output lane register for base_arr_dist.
// BASE_ARR_DIST_RDY_PASS_EN: lane also counts as free while it drains,
// giving a combinational o_r -> free path and full per-lane throughput.
module base_arr_dist_lane #(
  parameter int unsigned width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic             ld_h,
  input  logic [width-1:0] ld_d,
  input  logic             o_r,
  output logic             o_v,
  output logic             o_h,
  output logic [width-1:0] o_d,
  output logic             free
);

  logic             v_q;
  logic             h_q;
  logic [width-1:0] d_q;

  // Valid/hold: load wins over a simultaneous drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= 1'b0;
      h_q <= 1'b0;
    end else if (ld) begin
      v_q <= 1'b1;
      h_q <= ld_h;
    end else if (v_q && o_r) begin
      v_q <= 1'b0;
    end
  end

  // Payload changes only on load; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (ld) d_q <= ld_d;
  end

`ifdef BASE_ARR_DIST_RDY_PASS_EN
  assign free = ~v_q | o_r;
`else
  assign free = ~v_q;
`endif

  assign o_v = v_q;
  assign o_h = h_q;
  assign o_d = d_q;

endmodule

// File: rtl/base_prienc_hp.sv
// Priority encoder: one-hot grant of the lowest-index set request bit.
module base_prienc_hp #(
  parameter int unsigned n = 1
) (
  input  logic [n-1:0] req,
  output logic [n-1:0] gnt
);

  logic found;

  // Lowest set bit wins; later bits are masked once a grant is found.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      if (req[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/base_vlat_en.sv
// Enabled state register with synchronous active-high reset to a constant.
module base_vlat_en #(
  parameter int unsigned     width   = 1,
  parameter logic [width-1:0] rst_val = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  // Capture d when enabled; reset overrides.
  always_ff @(posedge clk) begin
    if (reset)   q <= rst_val;
    else if (en) q <= d;
  end

endmodule

// File: rtl/base_arr_dist.sv
// Round-robin 1-to-N distributor with hold (burst lock).
// Optional BASE_ARR_DIST_RDY_PASS_EN: lanes accept while draining
// (see base_arr_dist_lane).
module base_arr_dist
  import base_arr_dist_pkg::*;
#(
  parameter int unsigned ways  = 1,
  parameter int unsigned width = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  i_r,
  input  logic                  i_v,
  input  logic                  i_h,
  input  logic [width-1:0]      i_d,
  input  logic [ways-1:0]       o_r,
  output logic [ways-1:0]       o_v,
  output logic [ways-1:0]       o_h,
  output logic [ways*width-1:0] o_d,
  output logic [ways-1:0]       o_s
);

  localparam int unsigned PW = ptr_bits(ways);

  logic [ways-1:0]   free;
  logic [ways-1:0]   ge_mask;
  logic [ways-1:0]   lw_oh;
  logic [ways-1:0]   scan_tgt;
  logic [ways-1:0]   tgt;
  logic [ways-1:0]   ld;
  logic [2*ways-1:0] dbl;
  logic [2*ways-1:0] dbl_gnt;
  logic [PW-1:0]     p;
  logic [PW-1:0]     p_nxt;
  logic [PW-1:0]     lw;
  logic [PW-1:0]     g;
  logic              lk;
  logic              xfer;

  // Lanes at or above the pointer, and one-hot of the locked lane.
  always_comb begin
    ge_mask = '0;
    lw_oh   = '0;
    for (int unsigned i = 0; i < ways; i++) begin
      ge_mask[i] = (PW'(i) >= p);
      lw_oh[i]   = (lw == PW'(i));
    end
  end

  // Rotated scan: the low half only holds lanes >= p, the high half holds
  // all lanes, so the lowest set bit of the doubled vector is the first
  // free lane at or after p with wrap-around.
  assign dbl = {free, free & ge_mask};

  base_prienc_hp #(.n(2 * ways)) u_scan (
    .req (dbl),
    .gnt (dbl_gnt)
  );

  assign scan_tgt = dbl_gnt[ways-1:0] | dbl_gnt[2*ways-1:ways];
  assign tgt      = lk ? (free & lw_oh) : scan_tgt;
  assign o_s      = tgt;
  assign i_r      = |tgt;
  assign xfer     = i_v & i_r;
  assign ld       = {ways{xfer}} & tgt;

  // Index of the target lane and the pointer that follows it.
  always_comb begin
    g = '0;
    for (int unsigned i = 0; i < ways; i++) begin
      if (tgt[i]) g = PW'(i);
    end
    p_nxt = (g == PW'(ways - 1)) ? '0 : g + PW'(1);
  end

  base_vlat_en #(.width(PW), .rst_val('0)) u_p (
    .clk   (clk),
    .reset (reset),
    .en    (xfer & ~i_h),
    .d     (p_nxt),
    .q     (p)
  );

  base_vlat_en #(.width(1), .rst_val(1'b0)) u_lk (
    .clk   (clk),
    .reset (reset),
    .en    (xfer),
    .d     (i_h),
    .q     (lk)
  );

  base_vlat_en #(.width(PW), .rst_val('0)) u_lw (
    .clk   (clk),
    .reset (reset),
    .en    (xfer & i_h),
    .d     (g),
    .q     (lw)
  );

  for (genvar w = 0; w < ways; w++) begin : g_lane
    base_arr_dist_lane #(.width(width)) u_lane (
      .clk   (clk),
      .reset (reset),
      .ld    (ld[w]),
      .ld_h  (i_h),
      .ld_d  (i_d),
      .o_r   (o_r[w]),
      .o_v   (o_v[w]),
      .o_h   (o_h[w]),
      .o_d   (o_d[w*width +: width]),
      .free  (free[w])
    );
  end

endmodule

// File: tb/tb_base_arr_dist.sv
// Scoreboard bench for base_arr_dist (ways=4 and ways=1 instances, width=8).
module tb_base_arr_dist;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        i_r, i_v = 1'b0, i_h = 1'b0;
  logic [7:0]  i_d = '0;
  logic [3:0]  o_r = 4'hF, o_v, o_h, o_s;
  logic [31:0] o_d;

  logic        i_r1, i_v1 = 1'b0, i_h1 = 1'b0;
  logic [7:0]  i_d1 = '0;
  logic [0:0]  o_r1 = 1'b1, o_v1, o_h1, o_s1;
  logic [7:0]  o_d1;

  int checks = 0;
  int errors = 0;

  logic [8:0] q  [4][$];
  logic [8:0] q1 [$];

  always #5 clk = ~clk;

  base_arr_dist #(.ways(4), .width(8)) dut (
    .clk(clk), .reset(reset), .i_r(i_r), .i_v(i_v), .i_h(i_h), .i_d(i_d),
    .o_r(o_r), .o_v(o_v), .o_h(o_h), .o_d(o_d), .o_s(o_s)
  );

  base_arr_dist #(.ways(1), .width(8)) dut1 (
    .clk(clk), .reset(reset), .i_r(i_r1), .i_v(i_v1), .i_h(i_h1), .i_d(i_d1),
    .o_r(o_r1), .o_v(o_v1), .o_h(o_h1), .o_d(o_d1), .o_s(o_s1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle on the 4-lane DUT; check ready/select; queue the beat if accepted.
  task automatic step(input logic v, input logic h, input logic [7:0] d,
                      input logic [3:0] orr, input logic eir,
                      input logic [3:0] eos, input int lane);
    i_v = v; i_h = h; i_d = d; o_r = orr;
    #1;
    chk("i_r", {31'd0, i_r}, {31'd0, eir});
    chk("o_s", {28'd0, o_s}, {28'd0, eos});
    if (v && eir) q[lane].push_back({h, d});
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic [3:0] orr, input int n);
    i_v = 1'b0; i_h = 1'b0; o_r = orr;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: every beat leaving a lane must match the head of that lane's queue;
  // a valid lane with nothing expected is a stray beat.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!reset) begin
      for (int w = 0; w < 4; w++) begin
        if (o_v[w]) begin
          if (q[w].size() == 0) begin
            checks++; errors++;
            $display("FAIL stray_lane%0d actual=valid expected=empty", w);
          end else if (o_r[w]) begin
            e = q[w].pop_front();
            chk($sformatf("lane%0d_beat", w), {23'd0, o_h[w], o_d[w*8 +: 8]}, {23'd0, e});
          end
        end
      end
      if (o_v1[0]) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL stray_w1 actual=valid expected=empty");
        end else if (o_r1[0]) begin
          e = q1.pop_front();
          chk("w1_beat", {23'd0, o_h1[0], o_d1}, {23'd0, e});
        end
      end
    end
  end

  initial begin
    logic [3:0] oh;
    logic       eir;
    int         acc;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_v", {28'd0, o_v}, 32'd0);
    chk("rst_o_h", {28'd0, o_h}, 32'd0);
    chk("rst_o_v1", {31'd0, o_v1}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_i_r", {31'd0, i_r}, 32'd1);
    chk("rst_o_s", {28'd0, o_s}, 32'd1);

    // 1: rotation 0,1,2,3,0,... with all lanes ready
    for (int k = 0; k < 8; k++) begin
      oh = 4'b0001 << (k % 4);
      step(1'b1, 1'b0, 8'h10 + 8'(k), 4'hF, 1'b1, oh, k % 4);
    end
    idle(4'hF, 2);

    // 2: fill all lanes, stall, release lane 2
    step(1'b1, 1'b0, 8'h20, 4'h0, 1'b1, 4'b0001, 0);
    step(1'b1, 1'b0, 8'h21, 4'h0, 1'b1, 4'b0010, 1);
    step(1'b1, 1'b0, 8'h22, 4'h0, 1'b1, 4'b0100, 2);
    step(1'b1, 1'b0, 8'h23, 4'h0, 1'b1, 4'b1000, 3);
    step(1'b1, 1'b0, 8'h24, 4'h0, 1'b0, 4'b0000, 0);
    step(1'b1, 1'b0, 8'h24, 4'h0, 1'b0, 4'b0000, 0);
    step(1'b1, 1'b0, 8'h24, 4'b0100, 1'b0, 4'b0000, 0);
    step(1'b1, 1'b0, 8'h24, 4'b0100, 1'b1, 4'b0100, 2);
    idle(4'hF, 2);

    // 3: move p to 1, then burst A0,A1,A2 locked on lane 1; p becomes 2
    step(1'b1, 1'b0, 8'h30, 4'hF, 1'b1, 4'b1000, 3);
    step(1'b1, 1'b0, 8'h31, 4'hF, 1'b1, 4'b0001, 0);
    step(1'b1, 1'b1, 8'hA0, 4'hF, 1'b1, 4'b0010, 1);
    step(1'b1, 1'b1, 8'hA1, 4'hF, 1'b0, 4'b0000, 0);
    step(1'b1, 1'b1, 8'hA1, 4'hF, 1'b1, 4'b0010, 1);
    step(1'b1, 1'b0, 8'hA2, 4'hF, 1'b0, 4'b0000, 0);
    step(1'b1, 1'b0, 8'hA2, 4'hF, 1'b1, 4'b0010, 1);
    step(1'b0, 1'b0, 8'h00, 4'hF, 1'b1, 4'b0100, 0);
    step(1'b1, 1'b0, 8'h40, 4'hF, 1'b1, 4'b0100, 2);

    // 4: locked on lane 1 with lane 1 stalled; other lanes empty
    step(1'b1, 1'b0, 8'h50, 4'hF, 1'b1, 4'b1000, 3);
    step(1'b1, 1'b0, 8'h51, 4'hF, 1'b1, 4'b0001, 0);
    step(1'b1, 1'b1, 8'hB0, 4'b1101, 1'b1, 4'b0010, 1);
    repeat (3) step(1'b1, 1'b1, 8'hB1, 4'b1101, 1'b0, 4'b0000, 0);
    step(1'b1, 1'b1, 8'hB1, 4'hF, 1'b0, 4'b0000, 0);
    step(1'b1, 1'b1, 8'hB1, 4'hF, 1'b1, 4'b0010, 1);
    step(1'b1, 1'b0, 8'hB2, 4'hF, 1'b0, 4'b0000, 0);
    step(1'b1, 1'b0, 8'hB2, 4'hF, 1'b1, 4'b0010, 1);
    idle(4'hF, 2);

    // 6: fill lanes, lock on lane 1, reset mid-burst
    step(1'b1, 1'b0, 8'h60, 4'h0, 1'b1, 4'b0100, 2);
    step(1'b1, 1'b0, 8'h61, 4'h0, 1'b1, 4'b1000, 3);
    step(1'b1, 1'b0, 8'h62, 4'h0, 1'b1, 4'b0001, 0);
    step(1'b1, 1'b1, 8'h63, 4'h0, 1'b1, 4'b0010, 1);
    step(1'b1, 1'b1, 8'h64, 4'h0, 1'b0, 4'b0000, 0);
    reset = 1'b1; i_v = 1'b0; i_h = 1'b0;
    for (int w = 0; w < 4; w++) q[w].delete();
    @(posedge clk); #1;
    chk("mid_rst_o_v", {28'd0, o_v}, 32'd0);
    chk("mid_rst_o_h", {28'd0, o_h}, 32'd0);
    reset = 1'b0;
    step(1'b1, 1'b0, 8'h70, 4'hF, 1'b1, 4'b0001, 0);
    idle(4'hF, 2);

    // 5: ways=1 continuous stream
    acc = 0;
    for (int k = 0; k < 6; k++) begin
`ifdef BASE_ARR_DIST_RDY_PASS_EN
      eir = 1'b1;
`else
      eir = (k % 2 == 0);
`endif
      i_v1 = 1'b1; i_h1 = 1'b0; i_d1 = 8'h80 + 8'(acc); o_r1 = 1'b1;
      #1;
      chk("w1_i_r", {31'd0, i_r1}, {31'd0, eir});
      chk("w1_o_s", {31'd0, o_s1}, {31'd0, eir});
      if (eir) q1.push_back({1'b0, i_d1});
      @(posedge clk); #1;
      if (eir) acc++;
    end
    i_v1 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    for (int w = 0; w < 4; w++) chk($sformatf("drained_lane%0d", w), q[w].size(), 32'd0);
    chk("drained_w1", q1.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
